// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the two-input stream arbiter.
// Define STREAM_ARB_RR_EN to select round-robin arbitration. Without it the
// arbiter uses fixed priority, and in0 wins every contest.
package stream_arb_pkg;

    // Output-register occupancy: EMPTY means out_valid = 0, FULL means out_valid = 1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Source-select encoding, used for out_sel, the grant and last_grant.
    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

endpackage

// File: rtl/data_select.sv
// 2:1 word multiplexer. The sel input picks the granted requester's word.
module data_select
    import stream_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_in0,
    input  logic [DATA_WIDTH-1:0] i_in1,
    input  logic                  i_sel,
    output logic [DATA_WIDTH-1:0] o_data
);

    assign o_data = (i_sel == SRC_IN1) ? i_in1 : i_in0;

endmodule

// File: rtl/stream_arbiter.sv
// Two-requester stream arbiter with a single registered output slot.
// Define STREAM_ARB_RR_EN for round-robin arbitration between the requesters.
// By default the arbiter uses fixed priority, and in0 wins every contest.
//
// Handshake: a word moves on a channel only in a cycle where both valid and
// ready are 1. The output slot accepts a new word when it is empty or when it
// is draining (load_en = !out_valid || out_ready). The one granted requester
// sees ready = load_en. A word loaded at a clock edge appears on out_* at that
// edge. The slot holds it until the consumer takes it.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output state_t                o_dbg_state
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_sel;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel;
    logic                  w_load_en;
    logic                  w_in_xfer;

`ifdef STREAM_ARB_RR_EN
    logic r_last_grant;

    // Track the most recent winner so a contest goes to the other requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= SRC_IN1;
        end else if (w_in_xfer) begin
            r_last_grant <= w_sel;
        end
    end

    assign w_sel = in1_valid && (!in0_valid || (r_last_grant == SRC_IN0));
`else
    assign w_sel = in1_valid && !in0_valid;
`endif

    assign w_load_en = (r_state == EMPTY) || out_ready;
    assign in0_ready = rst_n && w_load_en && in0_valid && (w_sel == SRC_IN0);
    assign in1_ready = rst_n && w_load_en && in1_valid && (w_sel == SRC_IN1);
    assign w_in_xfer = in0_ready || in1_ready;

    data_select #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_data_select (
        .i_in0  (in0_data),
        .i_in1  (in1_data),
        .i_sel  (w_sel),
        .o_data (w_sel_data)
    );

    // State register for the output-slot occupancy FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill on an input transfer. Empty on a drain that has no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_in_xfer) w_state_nxt = FULL;
            FULL:    if (out_ready && !w_in_xfer) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Output word register. It loads only on an input transfer and otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_sel  <= SRC_IN0;
        end else if (w_in_xfer) begin
            r_out_data <= w_sel_data;
            r_out_sel  <= w_sel;
        end
    end

    assign out_data    = r_out_data;
    assign out_sel     = r_out_sel;
    assign out_valid   = (r_state == FULL);
    assign o_dbg_state = r_state;

endmodule
